// File: rtl/seg_display_pkg.sv
// Shared constants, types and helpers for the 4-digit 7-segment scanner.
// Everything here is active-low to match the display hardware.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIGIT_FIRST = 2'd3;
    localparam digit_idx_t DIGIT_LAST  = 2'd0;

    // One-hot-low anode enable for the selected digit.
    function automatic logic [3:0] an_decode(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing: per-slot cycle counter, digit select, frame counter
// and blink phase, plus frame boundary / frame start strobes.
module seg_scan_timer
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 125,
    localparam int SW = $clog2(SCAN_DIV),
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [SW-1:0] o_slot_cnt,
    output digit_idx_t    o_digit_sel,
    output logic          o_blink_phase,
    output logic          o_frame_end,
    output logic          o_frame_start
);

    logic [SW-1:0] r_slot_cnt;
    digit_idx_t    r_digit_sel;
    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_phase;

    logic w_slot_last;
    logic w_frame_end;
    logic w_blink_wrap;

    assign w_slot_last  = (r_slot_cnt == SW'(SCAN_DIV - 1));
    assign w_frame_end  = w_slot_last && (r_digit_sel == DIGIT_LAST);
    assign w_blink_wrap = (r_frame_cnt == FW'(BLINK_FRAMES - 1));

    // Slot counter wraps each slot; digit select steps 3,2,1,0 on wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_slot_cnt  <= '0;
            r_digit_sel <= DIGIT_FIRST;
        end else if (w_slot_last) begin
            r_slot_cnt  <= '0;
            r_digit_sel <= r_digit_sel - 2'd1;
        end else begin
            r_slot_cnt  <= r_slot_cnt + SW'(1);
        end
    end

    // Frames are counted always; blink phase flips every BLINK_FRAMES.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (w_blink_wrap) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + FW'(1);
            end
        end
    end

    assign o_slot_cnt    = r_slot_cnt;
    assign o_digit_sel   = r_digit_sel;
    assign o_blink_phase = r_blink_phase;
    assign o_frame_end   = w_frame_end;
    assign o_frame_start = (r_slot_cnt == '0) && (r_digit_sel == DIGIT_FIRST);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with frame-coherent
// latching, guard interval, 16-level PWM and whole-display blink.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] digit3,
    input  logic [6:0] digit2,
    input  logic [6:0] digit1,
    input  logic [6:0] digit0,
    input  logic [3:0] brightness,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int SW = $clog2(SCAN_DIV);

    logic [SW-1:0] w_slot_cnt;
    digit_idx_t    w_digit_sel;
    logic          w_blink_phase;
    logic          w_frame_end;
    logic          w_frame_start;
    logic          w_lit;

    logic [6:0] r_snap [4];
    logic [3:0] r_snap_bright;
    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_frame_tick;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_slot_cnt    (w_slot_cnt),
        .o_digit_sel   (w_digit_sel),
        .o_blink_phase (w_blink_phase),
        .o_frame_end   (w_frame_end),
        .o_frame_start (w_frame_start)
    );

    // Latch inputs only at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap        <= '{default: SEG_BLANK};
            r_snap_bright <= 4'd0;
        end else if (w_frame_end) begin
            r_snap[3]     <= digit3;
            r_snap[2]     <= digit2;
            r_snap[1]     <= digit1;
            r_snap[0]     <= digit0;
            r_snap_bright <= brightness;
        end
    end

    // Guard interval, PWM phase and blink mask combine into one enable.
    always_comb begin
        w_lit = (w_slot_cnt >= SW'(GUARD))
             && (w_slot_cnt[3:0] < r_snap_bright)
             && !(blink_en && w_blink_phase);
    end

    // Registered outputs so an/seg only ever change on a clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_BLANK;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_lit ? an_decode(w_digit_sel) : AN_OFF;
            r_seg        <= w_lit ? r_snap[w_digit_sel] : SEG_BLANK;
            r_frame_tick <= w_frame_start;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner against a
// cycle-index based reference model.
module tb_seg_display_scanner;

    localparam int SD = 32;
    localparam int GD = 2;
    localparam int BF = 2;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] d3, d2, d1, d0;
    logic [3:0] bri;
    logic       ben;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .SCAN_DIV     (SD),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit3     (d3),
        .digit2     (d2),
        .digit1     (d1),
        .digit0     (d0),
        .brightness (bri),
        .blink_en   (ben),
        .an         (an),
        .seg        (seg),
        .frame_tick (ft)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: mn = cycles since reset of the scan timeline.
    int         mn;
    logic [6:0] m_snap [4];
    int         m_bri;

    int         obs_lit [4];
    logic [6:0] obs_seg [4];
    int         obs_tot;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 4; k++) begin
            obs_lit[k] = 0;
            obs_seg[k] = 7'h7F;
        end
        obs_tot = 0;
    endtask

    // One clock: predict, advance model, clock, compare.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_ft;
        logic       lit;
        int pos, dg, sl, fr;
        if (!rst_n) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_ft  = 1'b0;
            mn    = 0;
            for (int k = 0; k < 4; k++) m_snap[k] = 7'h7F;
            m_bri = 0;
        end else begin
            pos = mn % FR;
            dg  = 3 - pos / SD;
            sl  = pos % SD;
            fr  = mn / FR;
            lit = (sl >= GD) && ((sl % 16) < m_bri)
               && !(ben && (((fr / BF) % 2) == 1));
            e_an  = lit ? ~(4'b0001 << dg) : 4'hF;
            e_seg = lit ? m_snap[dg] : 7'h7F;
            e_ft  = (pos == 0);
            if (pos == FR - 1) begin
                m_snap[3] = d3;
                m_snap[2] = d2;
                m_snap[1] = d1;
                m_snap[0] = d0;
                m_bri     = int'(bri);
            end
            mn++;
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_tick", 32'(ft), 32'(e_ft));
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] m;
            m = ~(4'b0001 << k);
            if (an == m) begin
                obs_lit[k]++;
                obs_seg[k] = seg;
                obs_tot++;
            end
        end
    endtask

    task automatic run_frame();
        clear_obs();
        repeat (FR) step();
    endtask

    initial begin
        rst_n = 1'b0;
        d3 = 7'h79; d2 = 7'h24; d1 = 7'h30; d0 = 7'h40;
        bri = 4'd15;
        ben = 1'b0;
        mn  = 0;
        m_bri = 0;
        for (int k = 0; k < 4; k++) m_snap[k] = 7'h7F;
        clear_obs();

        // Reset held three cycles, outputs dark.
        repeat (3) step();
        rst_n = 1'b1;

        // First frame after reset is blank.
        run_frame();
        chk("blank_frame1", 32'(obs_tot), 32'd0);

        // Full-scale brightness, scan order and duty.
        run_frame();
        chk("lit15_d3", 32'(obs_lit[3]), 32'd28);
        chk("lit15_d2", 32'(obs_lit[2]), 32'd28);
        chk("lit15_d1", 32'(obs_lit[1]), 32'd28);
        chk("lit15_d0", 32'(obs_lit[0]), 32'd28);
        chk("seg_d3", 32'(obs_seg[3]), 32'h79);
        chk("seg_d2", 32'(obs_seg[2]), 32'h24);
        chk("seg_d1", 32'(obs_seg[1]), 32'h30);
        chk("seg_d0", 32'(obs_seg[0]), 32'h40);

        // Brightness 4: takes effect one frame later.
        bri = 4'd4;
        run_frame();
        chk("bri_latched_late", 32'(obs_lit[3]), 32'd28);
        run_frame();
        chk("lit4_d3", 32'(obs_lit[3]), 32'd6);
        chk("lit4_d0", 32'(obs_lit[0]), 32'd6);

        // Brightness 0 is fully dark.
        bri = 4'd0;
        run_frame();
        run_frame();
        chk("bri0_dark", 32'(obs_tot), 32'd0);

        // Coherence: digit1 change mid-frame shows next frame.
        bri = 4'd15;
        run_frame();
        clear_obs();
        repeat (40) step();
        d1 = 7'h12;
        repeat (FR - 40) step();
        chk("coherent_old", 32'(obs_seg[1]), 32'h30);
        run_frame();
        chk("coherent_new", 32'(obs_seg[1]), 32'h12);

        // Blink: find a dark frame, then drop blink_en mid-slot.
        ben = 1'b1;
        for (int i = 0; i < 4 * FR; i++) begin
            if (((mn / FR / BF) % 2 == 1) && (mn % FR == 50)) break;
            step();
        end
        chk("blink_reached", 32'(mn % FR), 32'd50);
        chk("blink_dark", 32'(an), 32'hF);
        ben = 1'b0;
        step();
        chk("unblink_an", 32'(an), 32'b1011);
        ben = 1'b1;
        repeat (4 * FR) step();
        ben = 1'b0;

        // Mid-frame reset during the digit1 slot.
        while (mn % FR != 70) step();
        rst_n = 1'b0;
        step();
        chk("midrst_an", 32'(an), 32'hF);
        rst_n = 1'b1;
        run_frame();
        chk("midrst_blank", 32'(obs_tot), 32'd0);
        run_frame();
        chk("midrst_resume", 32'(obs_lit[3]), 32'd28);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(63) == 0) begin
                case ($urandom_range(3))
                    0: d0 = 7'($urandom);
                    1: d1 = 7'($urandom);
                    2: d2 = 7'($urandom);
                    default: d3 = 7'($urandom);
                endcase
            end
            if ($urandom_range(99) == 0) bri = 4'($urandom);
            if ($urandom_range(199) == 0) ben = ~ben;
            rst_n = ($urandom_range(1999) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
